// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Decode-stage hazard unit for a five-stage MIPS-style pipeline. It tracks the
// destination/timing of the instructions in E, M, W and one stage past W (WD).
// From that tracking it works out D-stage operand forwarding selects and a
// stall request. All outputs are combinational from the D inputs and the
// tracking registers.
//
// Optional feature: define HAZARD_MD_STALL_EN to add a mult/div busy counter.
// Any hi/lo/mult/div instruction in D then stalls while the unit is busy.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous active-high reset
//   rs_D, rt_D           source register numbers of the D instruction
//   Tuse_rs, Tuse_rt     cycles until D consumes each operand (3 = unused)
//   A3_D                 destination register of the D instruction (0 = none)
//   Tnew_D               cycles from E entry until the result is forwardable
//   src_D                result source: 0 ALU, 1 MEM, 2 PC+8, 3 hi/lo read
//   md_start_D           mult/div issue
//   md_type_D            0 mult, 1 div
//   md_use_D             any hi/lo/mult/div instruction
//   ForwardRSD/RTD       operand selects: 0 RF, 1 M ALU, 2 W, 3 WD,
//                        4 E PC+8, 5 M PC+8, 6 M hi/lo
//   stall                freeze F/D and insert a bubble into E
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] Tuse_rs,
  input  logic [1:0] Tuse_rt,
  input  logic [4:0] A3_D,
  input  logic [1:0] Tnew_D,
  input  logic [1:0] src_D,
  input  logic       md_start_D,
  input  logic       md_type_D,
  input  logic       md_use_D,
  output logic [2:0] ForwardRSD,
  output logic [2:0] ForwardRTD,
  output logic       stall
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_PC8 = 2'd2;
  localparam logic [1:0] SRC_MD  = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [1:0] src;
    logic       md_start;
  } entry_t;

  entry_t     d_entry_s;
  entry_t     e_r, m_r, w_r, wd_r;
  logic [3:0] rs_res_s, rt_res_s;
  logic       md_stall_s;
  logic       stall_s;
  logic       unused_s;

  // Moving one stage further down: Tnew counts down and saturates at zero.
  function automatic entry_t advance(input entry_t ent);
    entry_t res;
    res = ent;
    if (ent.tnew != 2'd0) begin
      res.tnew = ent.tnew - 2'd1;
    end else begin
      res.tnew = 2'd0;
    end
    return res;
  endfunction

  // Select code a matching M entry provides once its value is ready.
  function automatic logic [2:0] m_code(input logic [1:0] src);
    logic [2:0] code;
    case (src)
      SRC_ALU: code = 3'd1;
      SRC_PC8: code = 3'd5;
      SRC_MD:  code = 3'd6;
      default: code = 3'd0;  // a load is never ready while still in M
    endcase
    return code;
  endfunction

  // Resolve one operand: returns {stall, select}. The nearest producer wins;
  // while its value is not ready the select stays 0, and either a stall or
  // forwarding in a later pipeline stage supplies the operand.
  function automatic logic [3:0] resolve(input logic [4:0] r, input logic [1:0] tuse,
                                         input entry_t e, input entry_t m,
                                         input entry_t w, input entry_t wd);
    logic       st;
    logic [1:0] tnew;
    logic [2:0] code;
    st   = 1'b0;
    tnew = 2'd0;
    code = 3'd0;
    if (r == 5'd0 || tuse == 2'd3) begin
      code = 3'd0;  // $0 never matches; Tuse 3 means operand unused
    end else if (e.a3 == r) begin
      tnew = e.tnew;
      code = (e.src == SRC_PC8) ? 3'd4 : 3'd0;
    end else if (m.a3 == r) begin
      tnew = m.tnew;
      code = m_code(m.src);
    end else if (w.a3 == r) begin
      tnew = w.tnew;
      code = 3'd2;
    end else if (wd.a3 == r) begin
      tnew = wd.tnew;
      code = 3'd3;
    end else begin
      code = 3'd0;
    end
    st = (tnew > tuse);
    if (st || tnew != 2'd0) begin
      code = 3'd0;
    end else begin
      code = code;
    end
    return {st, code};
  endfunction

`ifdef HAZARD_MD_STALL_EN
  logic       e_md_type_r;
  logic [3:0] md_busy_r;

  // D fields as they would enter E.
  always_comb begin
    d_entry_s.a3       = A3_D;
    d_entry_s.tnew     = Tnew_D;
    d_entry_s.src      = src_D;
    d_entry_s.md_start = md_start_D;
  end

  // Busy counter: loaded once the mult/div has sat in E for its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_md_type_r <= 1'b0;
      md_busy_r   <= 4'd0;
    end else begin
      e_md_type_r <= stall_s ? 1'b0 : md_type_D;
      if (e_r.md_start) begin
        md_busy_r <= e_md_type_r ? 4'd10 : 4'd5;
      end else if (md_busy_r != 4'd0) begin
        md_busy_r <= md_busy_r - 4'd1;
      end else begin
        md_busy_r <= 4'd0;
      end
    end
  end

  // Hi/lo users wait while a mult/div is in E or still busy.
  always_comb begin
    md_stall_s = md_use_D & ((md_busy_r != 4'd0) | e_r.md_start);
  end

  // Fields that the forwarding logic never looks at.
  assign unused_s = ^{m_r.md_start, w_r.md_start, w_r.src, wd_r.md_start, wd_r.src};
`else
  // D fields as they would enter E; mult/div issue is not tracked.
  always_comb begin
    d_entry_s.a3       = A3_D;
    d_entry_s.tnew     = Tnew_D;
    d_entry_s.src      = src_D;
    d_entry_s.md_start = 1'b0;
  end

  // Without the busy counter there is never a mult/div stall.
  always_comb begin
    md_stall_s = 1'b0;
  end

  // Mult/div inputs and fields that nothing looks at in this build.
  assign unused_s = ^{md_start_D, md_type_D, md_use_D, e_r.md_start, m_r.md_start,
                      w_r.md_start, w_r.src, wd_r.md_start, wd_r.src};
`endif

  // Tracking pipeline: E takes D or a bubble; later stages always shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_r  <= '0;
      m_r  <= '0;
      w_r  <= '0;
      wd_r <= '0;
    end else begin
      e_r  <= stall_s ? '0 : d_entry_s;
      m_r  <= advance(e_r);
      w_r  <= advance(m_r);
      wd_r <= w_r;
    end
  end

  // Per-operand resolution and combined stall request.
  always_comb begin
    rs_res_s = resolve(rs_D, Tuse_rs, e_r, m_r, w_r, wd_r);
    rt_res_s = resolve(rt_D, Tuse_rt, e_r, m_r, w_r, wd_r);
    stall_s  = rs_res_s[3] | rt_res_s[3] | md_stall_s;
  end

  // Outputs are held quiet for as long as reset is high.
  always_comb begin
    if (reset) begin
      ForwardRSD = 3'd0;
      ForwardRTD = 3'd0;
      stall      = 1'b0;
    end else begin
      ForwardRSD = rs_res_s[2:0];
      ForwardRTD = rt_res_s[2:0];
      stall      = stall_s;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl: each D-stage instruction pushes its
// expected {stall, ForwardRSD, ForwardRTD}, and the popped entry is compared
// with the DUT outputs on the falling edge of the same cycle. Mult/div
// expectations follow HAZARD_MD_STALL_EN.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef HAZARD_MD_STALL_EN
  localparam logic MD_EN = 1'b1;
`else
  localparam logic MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, A3_D;
  logic [1:0] Tuse_rs, Tuse_rt, Tnew_D, src_D;
  logic       md_start_D, md_type_D, md_use_D;
  logic [2:0] ForwardRSD, ForwardRTD;
  logic       stall;

  typedef struct {
    string      tag;
    logic       stall;
    logic [2:0] fwd_rs;
    logic [2:0] fwd_rt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .Tuse_rs    (Tuse_rs),
    .Tuse_rt    (Tuse_rt),
    .A3_D       (A3_D),
    .Tnew_D     (Tnew_D),
    .src_D      (src_D),
    .md_start_D (md_start_D),
    .md_type_D  (md_type_D),
    .md_use_D   (md_use_D),
    .ForwardRSD (ForwardRSD),
    .ForwardRTD (ForwardRTD),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t x;
    x = exp_q.pop_front();
    check_eq({x.tag, ".stall"}, {31'd0, stall}, {31'd0, x.stall});
    check_eq({x.tag, ".rs"}, {29'd0, ForwardRSD}, {29'd0, x.fwd_rs});
    check_eq({x.tag, ".rt"}, {29'd0, ForwardRTD}, {29'd0, x.fwd_rt});
  endtask

  task automatic push_exp(input string tag, input logic st, input logic [2:0] frs,
                          input logic [2:0] frt);
    exp_t x;
    x.tag    = tag;
    x.stall  = st;
    x.fwd_rs = frs;
    x.fwd_rt = frt;
    exp_q.push_back(x);
  endtask

  // Present one D instruction for one cycle and score the outputs.
  task automatic step(input string tag,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                      input logic [4:0] a3, input logic [1:0] tnew, input logic [1:0] src,
                      input logic mds, input logic mdt, input logic mdu,
                      input logic e_st, input logic [2:0] e_rs, input logic [2:0] e_rt);
    rs_D = rs; rt_D = rt; Tuse_rs = tu_rs; Tuse_rt = tu_rt;
    A3_D = a3; Tnew_D = tnew; src_D = src;
    md_start_D = mds; md_type_D = mdt; md_use_D = mdu;
    push_exp(tag, e_st, e_rs, e_rt);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a would-be hazard on D: outputs must stay zero.
    reset = 1'b1;
    rs_D = 5'd8; rt_D = 5'd8; Tuse_rs = 2'd0; Tuse_rt = 2'd0;
    A3_D = 5'd8; Tnew_D = 2'd1; src_D = 2'd0;
    md_start_D = 1'b0; md_type_D = 1'b0; md_use_D = 1'b1;
    push_exp("in_reset", 1'b0, 3'd0, 3'd0);
    #2;
    compare_out();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addu $8 then beq $8: one stall, then ALU result from M; later W and WD.
    step("addu8",     5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("beq_stall", 5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    step("beq_fwd_m", 5'd8, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0);
    step("rt_fwd_w",  5'd0, 5'd8, 2'd3, 2'd1, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2);
    step("both_wd",   5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3);
    step("bubble0",   5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // lw $9 then addu rs=$9: one stall, then load result from W.
    step("lw9",       5'd0, 5'd0, 2'd3, 2'd3, 5'd9,  2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("lw_stall",  5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    step("lw_m_wait", 5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("lw_fwd_w",  5'd9, 5'd0, 2'd1, 2'd3, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0);

    // lw $11 then store data (Tuse 2): no stall; unused operands never match.
    step("lw11",      5'd0,  5'd0,  2'd3, 2'd3, 5'd11, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("sw_tuse2",  5'd0,  5'd11, 2'd3, 2'd2, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("unused_m",  5'd11, 5'd0,  2'd3, 2'd3, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("unused_w",  5'd11, 5'd0,  2'd3, 2'd3, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // jal then jr $31: PC+8 from E, then from M.
    step("jal",       5'd0,  5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("jr_fwd_e",  5'd31, 5'd0, 2'd0, 2'd3, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0);
    step("pc8_fwd_m", 5'd31, 5'd0, 2'd0, 2'd3, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0);

    // Register 0 never matches.
    step("w_zero",    5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("use_zero",  5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // Two writers of $5: nearest (E, not ready) wins over the ready M copy.
    step("addu5_a",   5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("addu5_b",   5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("nearest",   5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // mfhi $12 then a consumer with rs==rt: hi/lo read from M on both.
    step("mfhi12",    5'd0,  5'd0,  2'd3, 2'd3, 5'd12, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("bubble1",   5'd0,  5'd0,  2'd3, 2'd3, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step("md_fwd_m",  5'd12, 5'd12, 2'd1, 2'd1, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 3'd6);

    // div then mfhi: 1 cycle for div in E plus 10 busy cycles.
    step("div",       5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 11; i++) begin
      step($sformatf("div_busy%0d", i), 5'd0, 5'd0, 2'd3, 2'd3, 5'd13, 2'd1, 2'd3,
           1'b0, 1'b0, 1'b1, MD_EN, 3'd0, 3'd0);
    end
    step("div_done",  5'd0, 5'd0, 2'd3, 2'd3, 5'd13, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);

    // mult, then reset while mfhi is held in the busy stall.
    step("mult",      5'd0, 5'd0, 2'd3, 2'd3, 5'd0,  2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    step("mult_e",    5'd0, 5'd0, 2'd3, 2'd3, 5'd14, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, MD_EN, 3'd0, 3'd0);
    push_exp("mult_busy", MD_EN, 3'd0, 3'd0);
    #2;
    compare_out();
    reset = 1'b1;
    push_exp("mid_reset", 1'b0, 3'd0, 3'd0);
    #1;
    compare_out();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 5'd0, 5'd0, 2'd3, 2'd3, 5'd14, 2'd1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports rs_D / rt_D, input, 5 each, source register numbers of the instruction in D.
REQ-004 SHALL have ports Tuse_rs / Tuse_rt, input, 2 each, cycles until D instruction consumes operand (0 branch/jr, 1 ALU, 2 store data, 3 unused).
REQ-005 SHALL have port A3_D, input, 5, destination register of D instruction (0 = none).
REQ-006 SHALL have port Tnew_D, input, 2, cycles from E entry until result forwardable (ALU 1, MEM 2, PC8 0, MD 1).
REQ-007 SHALL have port src_D, input, 2, result source: 0 ALU, 1 MEM, 2 PC8, 3 MD (hi/lo read).
REQ-008 SHALL have ports md_start_D (mult/div issue), md_type_D (0 mult, 1 div), md_use_D (any hi/lo/mult/div op), input, 1 each.
REQ-009 SHALL have ports ForwardRSD / ForwardRTD, output, 3 each, D-stage operand mux selects.
REQ-010 SHALL have port stall, output, 1, freezes F/D and inserts E bubble.

Function
REQ-011 SHALL hold tracking entries E, M, W, WD, each {A3, Tnew, src, md_start}.
REQ-012 SHALL per cycle: E<=D fields if !stall, else bubble (A3=0, Tnew=0, md_start=0); M<=E, W<=M, WD<=W unconditionally.
REQ-013 SHALL decrement Tnew on each E->M and M->W transfer, saturating at 0.
REQ-014 SHALL match an operand to a stage when A3!=0 and A3 equals rs_D/rt_D and Tuse!=3; nearest stage wins (E>M>W>WD).
REQ-015 SHALL assert stall when the winning stage's Tnew > operand Tuse, for either operand.
REQ-016 SHALL encode select: 0 register file, 1 ALU result in M, 2 result in W, 3 result in WD, 4 PC+8 in E, 5 PC+8 in M, 6 MD read in M.
REQ-017 SHALL select 4 for E match with src PC8; 1/5/6 for M match with Tnew 0 and src ALU/PC8/MD; 2 for W match; 3 for WD match.
REQ-018 SHALL output select 0 when no match, or when matched value not yet ready (stall or later-stage forwarding covers it).
REQ-019 SHALL be combinational from inputs and tracking registers to ForwardRSD/ForwardRTD/stall (zero latency).
REQ-020 SHALL treat register 0 as never matching, even if A3 and rs/rt are 0.
REQ-021 SHALL, with rs_D==rt_D, produce identical selects on both outputs.

Reset
REQ-022 SHALL on reset clear all tracking entries to bubble and MD busy counter to 0, immediately (asynchronous), including mid-stall or mid-busy.
REQ-023 SHALL drive ForwardRSD=0, ForwardRTD=0, stall=0 while reset is high.

Configuration
REQ-024 SHALL, with macro HAZARD_MD_STALL_EN defined, contain a 4-bit busy counter loaded with 5 (mult) or 10 (div) the cycle after entry E has md_start=1, decrementing to 0.
REQ-025 SHALL, with HAZARD_MD_STALL_EN defined, additionally assert stall when md_use_D=1 and (busy counter!=0 or entry E md_start=1).
REQ-026 SHALL, without HAZARD_MD_STALL_EN, omit the counter; md inputs ignored, MD stall never asserted.

Verification
REQ-027 SHALL verify: addu writes $8 (Tnew 1, ALU), next beq uses $8 (Tuse 0) -> stall=1 one cycle, then ForwardRSD=1.
REQ-028 SHALL verify: lw $9 then addu rs=$9 (Tuse 1) -> stall=1 one cycle, then ForwardRSD=2 when lw in W.
REQ-029 SHALL verify: jal (A3=31, PC8) then jr $31 -> no stall, ForwardRSD=4; one instruction later ForwardRSD=5.
REQ-030 SHALL verify: A3=$0 producer then consumer rs=$0 -> ForwardRSD=0, stall=0.
REQ-031 SHALL verify (macro defined): div issued, mfhi following -> stall held 11 cycles (1 E + 10 busy), then released; macro undefined -> stall=0.
REQ-032 SHALL verify: reset asserted during MD stall -> stall=0 and selects 0 same cycle, counter 0 after release.
